// File: rtl/data_mem_pkg.sv
// Shared types and fill-pattern helper for the dual-read data memory.
package data_mem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int INIT_DESC = 0;
  localparam int INIT_ZERO = 1;

  // Fill word for address idx; the caller truncates to its word width.
  function automatic logic [31:0] init_word(input int mode, input int depth, input int idx);
    if (mode == INIT_ZERO) return '0;
    return 32'(depth - 1 - idx);
  endfunction

endpackage

// File: rtl/data_mem_init_seq.sv
// Init/run sequencer: walks cnt over the array after reset or clr and owns the
// array write port, muxing the fill pattern against user writes.
module data_mem_init_seq
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int INIT_MODE  = INIT_DESC
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  clr,
  input  logic                  user_we,
  input  logic [ADDR_WIDTH-1:0] user_waddr,
  input  logic [DATA_WIDTH-1:0] user_wdata,
  output logic                  ready,
  output state_t                state,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_n;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_n;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mem_we    = 1'b0;
    mem_waddr = user_waddr;
    mem_wdata = user_wdata;
    case (state)
      INIT: begin
        mem_we    = nReset;
        mem_waddr = cnt;
        mem_wdata = DATA_WIDTH'(init_word(INIT_MODE, DEPTH, int'(cnt)));
        cnt_n     = cnt + 1'b1;
        if (cnt == LAST) state_n = RUN;
      end
      RUN: begin
        // A write coinciding with clr is dropped; the fill will overwrite anyway.
        mem_we = user_we & ~clr;
        if (clr) begin
          state_n = INIT;
          cnt_n   = '0;
        end
      end
      default: state_n = INIT;
    endcase
  end

  assign ready = (state == RUN);

endmodule

// File: rtl/data_mem_dp.sv
// Data memory with one write port, two registered read ports (write-first
// bypass), range checking and a sequenced initialiser.
module data_mem_dp
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int INIT_MODE  = INIT_DESC
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic                  ready,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  reg [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic ok_w, ok_a, ok_b;
  logic acc_w, acc_a, acc_b;
  logic wr_run, hit_a, hit_b;

  assign ok_w = ({1'b0, waddr}   < DEPTH_L);
  assign ok_a = ({1'b0, raddr_a} < DEPTH_L);
  assign ok_b = ({1'b0, raddr_b} < DEPTH_L);

  // Accepted accesses: only in RUN; a write alongside clr is not accepted.
  assign acc_w = ready & we & ~clr;
  assign acc_a = ready & re_a;
  assign acc_b = ready & re_b;

  // wr_run is the user write that actually lands this cycle; reads bypass it.
  assign wr_run = acc_w & ok_w;
  assign hit_a  = wr_run & (waddr == raddr_a);
  assign hit_b  = wr_run & (waddr == raddr_b);

  data_mem_init_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_MODE  (INIT_MODE)
  ) u_seq (
    .clk        (clk),
    .nReset     (nReset),
    .clr        (clr),
    .user_we    (we & ok_w),
    .user_waddr (waddr),
    .user_wdata (wdata),
    .ready      (ready),
    .state      (state),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid_a <= acc_a;
      rvalid_b <= acc_b;
      addr_err <= (acc_w & ~ok_w) | (acc_a & ~ok_a) | (acc_b & ~ok_b);
      if (acc_a) rdata_a <= !ok_a ? '0 : (hit_a ? wdata : mem[raddr_a]);
      if (acc_b) rdata_b <= !ok_b ? '0 : (hit_b ? wdata : mem[raddr_b]);
    end
  end

endmodule

// File: tb/tb_data_mem_dp.sv
// Directed bench: three instances (256/desc, 200/desc, 256/zero) exercised by a
// vector table plus hand sequences for fill timing, range errors, clr and reset.
module tb_data_mem_dp;

  logic       clk = 1'b0;
  logic       nreset [3];
  logic       clr [3];
  logic       we [3];
  logic [7:0] waddr [3];
  logic [7:0] wdata [3];
  logic       re_a [3];
  logic [7:0] raddr_a [3];
  logic       re_b [3];
  logic [7:0] raddr_b [3];
  logic [7:0] rdata_a [3];
  logic [7:0] rdata_b [3];
  logic       rvalid_a [3];
  logic       rvalid_b [3];
  logic       ready [3];
  logic       addr_err [3];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .INIT_MODE(0)) u_d0 (
    .clk(clk), .nReset(nreset[0]), .clr(clr[0]), .we(we[0]), .waddr(waddr[0]),
    .wdata(wdata[0]), .re_a(re_a[0]), .raddr_a(raddr_a[0]), .re_b(re_b[0]),
    .raddr_b(raddr_b[0]), .rdata_a(rdata_a[0]), .rdata_b(rdata_b[0]),
    .rvalid_a(rvalid_a[0]), .rvalid_b(rvalid_b[0]), .ready(ready[0]), .addr_err(addr_err[0]));

  data_mem_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .INIT_MODE(0)) u_d1 (
    .clk(clk), .nReset(nreset[1]), .clr(clr[1]), .we(we[1]), .waddr(waddr[1]),
    .wdata(wdata[1]), .re_a(re_a[1]), .raddr_a(raddr_a[1]), .re_b(re_b[1]),
    .raddr_b(raddr_b[1]), .rdata_a(rdata_a[1]), .rdata_b(rdata_b[1]),
    .rvalid_a(rvalid_a[1]), .rvalid_b(rvalid_b[1]), .ready(ready[1]), .addr_err(addr_err[1]));

  data_mem_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .INIT_MODE(1)) u_d2 (
    .clk(clk), .nReset(nreset[2]), .clr(clr[2]), .we(we[2]), .waddr(waddr[2]),
    .wdata(wdata[2]), .re_a(re_a[2]), .raddr_a(raddr_a[2]), .re_b(re_b[2]),
    .raddr_b(raddr_b[2]), .rdata_a(rdata_a[2]), .rdata_b(rdata_b[2]),
    .rvalid_a(rvalid_a[2]), .rvalid_b(rvalid_b[2]), .ready(ready[2]), .addr_err(addr_err[2]));

  typedef struct {
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [7:0] raddr_a;
    logic       re_b;
    logic [7:0] raddr_b;
    logic       exp_va;
    logic [7:0] exp_a;
    logic       exp_vb;
    logic [7:0] exp_b;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobes are single-cycle: cleared right after every edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0; re_a[k] = 1'b0; re_b[k] = 1'b0; clr[k] = 1'b0;
    end
  endtask

  task automatic drive(input int k, input logic w, input logic [7:0] wa, input logic [7:0] wd,
                       input logic ra, input logic [7:0] aa, input logic rb, input logic [7:0] ab);
    we[k] = w; waddr[k] = wa; wdata[k] = wd;
    re_a[k] = ra; raddr_a[k] = aa; re_b[k] = rb; raddr_b[k] = ab;
  endtask

  task automatic wait_ready(input int k, input int bound, output int n);
    n = 0;
    while (!ready[k] && n < bound) begin
      step();
      n++;
    end
  endtask

  // Reads addresses 0..n-1 on port A, one per cycle, against a model pattern.
  task automatic sweep(input int k, input int n, input int depth, input int mode);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mode == 1 ? 8'h00 : 8'(depth - 1 - i));
      drive(k, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 1'b0, 8'h00);
      step();
      e = exp_q.pop_front();
      check("sweep_valid", rvalid_a[k], 1);
      check("sweep_data", rdata_a[k], e);
    end
  endtask

  initial begin
    int first [3];
    int n;

    vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1, 8'hEF, 1'b1, 8'hEF, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hEF, 1'b0, 8'hEF, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 1'b1, 8'h34, 1'b1, 8'hA5, 1'b1, 8'hCB, 1'b0};
    vecs[4] = '{1'b1, 8'h40, 8'h5A, 1'b1, 8'h40, 1'b1, 8'h40, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0};
    vecs[6] = '{1'b1, 8'h41, 8'h12, 1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 8'h12, 1'b1, 8'hBD, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 1'b0, 8'hBD, 1'b0};

    for (int k = 0; k < 3; k++) begin
      nreset[k] = 1'b0; clr[k] = 1'b0;
      drive(k, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    end

    // Reset for three cycles, then check reset values.
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", ready[k], 0);
      check("rst_rvalid_a", rvalid_a[k], 0);
      check("rst_rvalid_b", rvalid_b[k], 0);
      check("rst_rdata_a", rdata_a[k], 0);
      check("rst_rdata_b", rdata_b[k], 0);
      check("rst_addr_err", addr_err[k], 0);
    end

    // Fill timing: ready rises on edge DEPTH after release.
    for (int k = 0; k < 3; k++) begin
      nreset[k] = 1'b1;
      first[k] = 0;
    end
    for (int e = 1; e <= 600; e++) begin
      step();
      for (int k = 0; k < 3; k++)
        if (ready[k] && first[k] == 0) first[k] = e;
      if (first[0] != 0 && first[1] != 0 && first[2] != 0) break;
    end
    check("fill_edges_d0", first[0], 256);
    check("fill_edges_d1", first[1], 200);
    check("fill_edges_d2", first[2], 256);

    // Table-driven reads, writes and bypass on the 256-deep instance.
    for (int i = 0; i < 8; i++) begin
      drive(0, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re_a, vecs[i].raddr_a,
            vecs[i].re_b, vecs[i].raddr_b);
      step();
      check($sformatf("vec%0d_rvalid_a", i), rvalid_a[0], vecs[i].exp_va);
      check($sformatf("vec%0d_rdata_a", i), rdata_a[0], vecs[i].exp_a);
      check($sformatf("vec%0d_rvalid_b", i), rvalid_b[0], vecs[i].exp_vb);
      check($sformatf("vec%0d_rdata_b", i), rdata_b[0], vecs[i].exp_b);
      check($sformatf("vec%0d_addr_err", i), addr_err[0], vecs[i].exp_err);
    end

    // Range checks on the 200-deep instance.
    drive(1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
    step();
    check("rng_rd0_data", rdata_a[1], 8'hC7);
    check("rng_rd0_err", addr_err[1], 0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC8, 1'b1, 8'hC7);
    step();
    check("rng_oob_valid", rvalid_a[1], 1);
    check("rng_oob_data", rdata_a[1], 0);
    check("rng_oob_err", addr_err[1], 1);
    check("rng_last_data", rdata_b[1], 8'h00);
    step();
    check("rng_err_pulse", addr_err[1], 0);
    drive(1, 1'b1, 8'hC8, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    step();
    check("rng_wr_err", addr_err[1], 1);
    check("rng_wr_novalid", rvalid_a[1], 0);
    drive(1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h10, 1'b0, 8'h00);
    step();
    check("rng_wr2_err", addr_err[1], 1);
    check("rng_wr2_rd", rdata_a[1], 8'hB7);
    sweep(1, 200, 200, 0);

    // clr with a concurrent write: write dropped, read completes, ready drops.
    drive(0, 1'b1, 8'h05, 8'h77, 1'b1, 8'h05, 1'b0, 8'h00);
    clr[0] = 1'b1;
    step();
    check("clr_ready", ready[0], 0);
    check("clr_rvalid", rvalid_a[0], 1);
    check("clr_rdata", rdata_a[0], 8'hFA);
    drive(0, 1'b1, 8'h06, 8'h99, 1'b1, 8'h06, 1'b1, 8'hFF);
    step();
    check("notrdy_rvalid_a", rvalid_a[0], 0);
    check("notrdy_rvalid_b", rvalid_b[0], 0);
    check("notrdy_rdata_a", rdata_a[0], 8'hFA);
    check("notrdy_err", addr_err[0], 0);
    wait_ready(0, 600, n);
    check("clr_fill_edges", n + 1, 256);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 1'b1, 8'h06);
    step();
    check("clr_rd05", rdata_a[0], 8'hFA);
    check("clr_rd06", rdata_b[0], 8'hF9);

    // Reset mid-INIT on the zero-fill instance after overwriting everything.
    for (int i = 0; i < 256; i++) begin
      drive(2, 1'b1, 8'(i), 8'h11, 1'b0, 8'h00, 1'b0, 8'h00);
      step();
    end
    drive(2, 1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 1'b1, 8'hFF);
    step();
    check("fill11_a", rdata_a[2], 8'h11);
    check("fill11_b", rdata_b[2], 8'h11);
    clr[2] = 1'b1;
    step();
    repeat (100) step();
    check("midinit_ready", ready[2], 0);
    nreset[2] = 1'b0;
    step();
    check("midrst_ready", ready[2], 0);
    check("midrst_rdata", rdata_a[2], 0);
    nreset[2] = 1'b1;
    wait_ready(2, 600, n);
    check("midrst_fill_edges", n, 256);
    sweep(2, 256, 256, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_dp.md
# data_mem_dp

Parametrised successor to the accumulator-side data memory: one write port, two independent registered read ports (operand and indirect-address paths), and a sequenced initialiser that fills the array over DEPTH cycles instead of in a single reset step. It sits between the accumulator/ALU datapath and the control unit. The `ready` output tells the control unit when the memory is usable. A `clr` command re-runs initialisation without a system reset.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 8, address width in bits
- DEPTH, 256, number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_WIDTH
- INIT_MODE, 0, fill pattern: 0 = word[i] = (DEPTH-1-i) truncated to DATA_WIDTH; 1 = all zero
- clk  in  1  rising-edge clock
- nReset  in  1  reset nReset, synchronous, active-low
- clr  in  1  single-cycle request to re-initialise; honoured only in RUN
- we  in  1  write enable
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data (accumulator output)
- re_a / re_b  in  1  read enable, port A / B
- raddr_a / raddr_b  in  ADDR_WIDTH  read address, port A / B
- rdata_a / rdata_b  out  DATA_WIDTH  registered read data
- rvalid_a / rvalid_b  out  1  one-cycle strobe; rdata is valid this cycle
- ready  out  1  high in RUN; array accepts reads and writes
- addr_err  out  1  one-cycle pulse; an accepted access used address ≥ DEPTH

## Operation
- FSM has two states: INIT and RUN.
- INIT:
  - Entered when nReset is low at a clock edge, or in RUN when clr is high.
  - Entry loads init counter cnt to 0.
  - Each cycle in INIT with nReset high: write the pattern word to array[cnt], then cnt increments.
  - After the write of cnt = DEPTH-1, the next state is RUN.
- RUN:
  - Accepts we/re_a/re_b every cycle.
  - clr forces INIT on the next edge. A write in the same cycle as clr is dropped; reads in that cycle still complete.
- While not ready: we, re_a and re_b are ignored. rvalid stays 0 and rdata holds its last value. No addr_err is raised.
- Write: when we=1 and waddr < DEPTH, array[waddr] ← wdata at the edge. When waddr ≥ DEPTH, nothing is written and addr_err pulses.
- Read, per port independently:
  - re=1 registers array[raddr] into rdata and asserts rvalid the next cycle.
  - raddr ≥ DEPTH returns 0, still asserts rvalid, and pulses addr_err.
- Read-during-write, same address, same cycle: the read returns the new wdata (write-first bypass). This applies to both ports at once.
- Both ports may read the same address in the same cycle; both return identical data.
- addr_err is the OR of all three ports' range violations in one cycle.
- Array contents are not cleared by anything except INIT.

## Timing
- Reset values, forced at any edge with nReset low: rdata_a = rdata_b = 0, rvalid_a = rvalid_b = 0, ready = 0, addr_err = 0, state = INIT, cnt = 0.
- Init duration: DEPTH cycles after the first edge with nReset high. ready rises on edge DEPTH (counting edges 1..DEPTH after release).
- Reset mid-INIT or mid-RUN: takes effect at the next edge and restarts from cnt = 0. Partial fill contents are don't-care until re-filled.
- clr in RUN: ready drops at the next edge. Re-initialisation then takes DEPTH cycles.
- Read latency: exactly 1 cycle (address at edge N, data and rvalid after edge N+1 until edge N+2). Full throughput of one read per port per cycle.
- Write latency: the written data is visible to a read issued on the following cycle. It is visible in the same cycle via the bypass.
- addr_err is registered and aligned with the rvalid of the offending read, or one cycle after the offending write.

## Structure
- Package data_mem_pkg holds:
  - state enum {INIT, RUN}
  - constants INIT_DESC = 0 and INIT_ZERO = 1
  - function init_word(idx) returning the fill pattern for a given INIT_MODE
- Sub-module data_mem_init_seq holds the FSM, the cnt counter, pattern generation, and the ready output. It drives the internal write mux (init write vs. user write).
- Top level holds:
  - the array, declared as a plain reg array with no reset on storage
  - the two read registers and the bypass compare
  - range checks

## Test plan
- Reset then fill, DEPTH=256, INIT_MODE=0: hold nReset low for 3 cycles, then release → ready rises exactly 256 edges later. Read 0x00 → 0xFF, read 0xFF → 0x00, read 0x10 → 0xEF.
- Write then read back: write 0xA5 to 0x33; next cycle read port A 0x33 and port B 0x34 → rdata_a = 0xA5, rdata_b = 0xCB, both rvalid = 1 for one cycle.
- Bypass: in the same cycle write 0x5A to 0x40 and read 0x40 on both ports → both rdata = 0x5A on the next cycle.
- Range check, DEPTH=200, ADDR_WIDTH=8: read 0xC8 → rdata = 0, rvalid = 1, addr_err = 1. Write 0xFF to 0xC8 → addr_err = 1, and a read of 0x00..0xC7 shows no change.
- clr with a concurrent write of 0x77 to 0x05 in RUN → ready = 0 on the next edge. While not ready, a we and re are ignored (no rvalid). After 256 cycles ready = 1 and read 0x05 → 0xFA.
- Reset mid-INIT at cnt = 100, INIT_MODE=1, after prior writes of 0x11 everywhere → ready only 256 cycles after release. Every address then reads 0x00.
